mixcolumns_engine: RTL and testbench
====================================

# mixcolumns_engine

Parametrised, column-serial MixColumns / InvMixColumns unit with a valid/ready handshake, shared by the encryption and decryption round datapaths. It processes a 128-bit AES state over 4/COLS_PER_CYCLE beats, so area can be traded against latency. InvMixColumns is computed as a pre-process step followed by the forward MixColumns network on the same hardware. A bypass mode serves the final round.

## Interface
- COLS_PER_CYCLE, default 1: columns processed per beat; legal values 1, 2, 4. Any other value is an elaboration error.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a state is offered.
- in_ready  output  1  the engine accepts a state this cycle.
- mode_i  input  2  sampled only on an accepted input:
  - 00: MixColumns.
  - 01: InvMixColumns.
  - 10: bypass.
  - 11: reserved, treated as bypass.
- state_i  input  `TEXT_WIDTH  input state.
- out_valid  output  1  state_o holds a result.
- out_ready  input  1  downstream accepts a result.
- state_o  output  `TEXT_WIDTH  result state.

## Operation
- Byte layout:
  - Column c occupies bits [127-32c : 96-32c].
  - Row 0 is the most significant byte of each column.
- Forward column transform, with rows a0..a3 and indices mod 4:
  - o_r = X2(a_r ^ a_{r+1}) ^ a_{r+1} ^ a_{r+2} ^ a_{r+3}.
  - X2(x) is a left shift by 1, XORed with 8'h1B when x[7] = 1.
- Inverse column transform:
  - Pre-process: p_r = a_r ^ X2(X2(a_r ^ a_{r+2})).
  - Then apply the forward transform to p.
- Bypass: columns are copied unchanged.
- On accept:
  - state_i is latched into a 128-bit working register.
  - mode_i is latched.
  - The beat counter is cleared.
- Each BUSY beat k (k = 0 .. 4/COLS_PER_CYCLE-1) transforms columns k·C .. k·C+C-1 in place, where C = COLS_PER_CYCLE.
- Only C column transform instances are built. They are shared between the forward and inverse paths through the pre-process mux.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, latch and go to BUSY.
  - BUSY: in_ready = 0. Advance one beat per cycle. After the last beat, go to DONE.
  - DONE: out_valid = 1 and state_o = working register.
    - out_ready = 1 with in_valid = 1: accept the new state and go to BUSY.
    - out_ready = 1 with in_valid = 0: go to IDLE.
    - out_ready = 0: hold state_o stable.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- in_valid is ignored while in BUSY. The upstream stage must hold its data until in_ready is high.
- state_i and mode_i changing while BUSY have no effect.

## Timing
- Reset values:
  - FSM state = IDLE.
  - out_valid = 0.
  - in_ready = 1 in the first cycle after reset.
  - state_o = 0.
  - Beat counter = 0.
  - Latched mode = 00.
- Reset mid-operation, in BUSY or DONE:
  - The next cycle is IDLE.
  - The in-flight result is discarded.
  - No out_valid pulse is produced.
- Latency from accept edge to out_valid high is 4/C + 1 cycles: 5, 3 or 2 for C = 1, 2, 4.
- Bypass takes the same latency; beats still run, but without the transform.
- Throughput with out_ready held high is one state every 4/C + 1 cycles. The DONE→BUSY chaining removes the IDLE bubble.
- The beat counter is log2(4/C) bits. It wraps to 0 on the transition into DONE.
- For C = 4, BUSY lasts exactly one cycle.
- state_o is driven directly from the register, so no combinational path exists from state_i to state_o.
- out_ready → in_ready is the only combinational input-to-output path.

## Test plan
- MixColumns, for every C in {1, 2, 4}:
  - Stimulus: state_i = 128'hdb135345_f20a225c_01010101_2d26314c.
  - Required: state_o = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, with out_valid rising exactly 4/C + 1 cycles after the accept.
- InvMixColumns:
  - Stimulus: state_i = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8.
  - Required: state_o = 128'hdb135345_f20a225c_01010101_2d26314c.
  - Also: 128'hc6c6c6c6_d4d4d4d5_… round-trips through forward and then inverse back to the original.
- Bypass:
  - mode_i = 10 with state_i = 128'h00112233_44556677_8899aabb_ccddeeff returns the input unchanged.
  - mode_i = 11 returns the input unchanged.
- Backpressure and chaining:
  - Hold out_ready = 0 for 10 cycles in DONE. state_o must stay stable and in_ready must stay 0.
  - Then assert out_ready together with in_valid. A second state must be accepted that cycle, and its result must match its own mode.
- Mid-operation and reset:
  - Change state_i and mode_i during BUSY. The result must be unaffected.
  - Assert rst on beat 1 with C = 1. Required: IDLE, out_valid = 0, state_o = 0 on the next cycle.
  - A fresh transfer after that reset must produce correct results.
- Randomised: at least 1000 random states and modes with random out_ready stalls, compared against a reference model. Every accepted input must produce exactly one output, in order.

Source files
------------

// File: rtl/mixcolumns_engine.sv
// Column-serial AES MixColumns / InvMixColumns engine with bypass and valid/ready on both sides.
// Latency 4/COLS_PER_CYCLE + 1 cycles from accept to out_valid; out_ready low holds the result in DONE.
`ifndef TEXT_WIDTH
`define TEXT_WIDTH 128
`endif

module mixcolumns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             mode_i,
    input  logic [`TEXT_WIDTH-1:0] state_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [`TEXT_WIDTH-1:0] state_o
);
    localparam int BEATS = 4 / COLS_PER_CYCLE;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mixcolumns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [0:3][7:0] a;
        logic [0:3][7:0] o;
        a = c;
        for (int r = 0; r < 4; r++)
            o[r] = xt(a[r] ^ a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
        return o;
    endfunction

    // Folds the inverse matrix into the forward one: p_r = 5*a_r ^ 4*a_{r+2}.
    function automatic logic [31:0] inv_pre(input logic [31:0] c);
        logic [0:3][7:0] a;
        logic [0:3][7:0] o;
        a = c;
        for (int r = 0; r < 4; r++)
            o[r] = a[r] ^ xt(xt(a[r] ^ a[(r+2)%4]));
        return o;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CW-1:0]    beat_q, beat_d;
    logic [0:3][31:0] work_q, work_d;
    logic [1:0]       base;
    logic [31:0]      col_out [COLS_PER_CYCLE];
    logic             accept;

    assign base = 2'(beat_q * COLS_PER_CYCLE);

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
        logic [31:0] col_in;
        assign col_in     = work_q[base + 2'(i)];
        assign col_out[i] = mix_fwd(mode_q[0] ? inv_pre(col_in) : col_in);
    end

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign state_o   = work_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        beat_d  = beat_q;
        work_d  = work_q;
        case (state_q)
            S_IDLE: ;
            S_BUSY: begin
                if (!mode_q[1]) begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++)
                        work_d[base + 2'(i)] = col_out[i];
                end
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = S_DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_DONE: if (out_ready && !in_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d = S_BUSY;
            mode_d  = mode_i;
            beat_d  = '0;
            work_d  = state_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            beat_q  <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            beat_q  <= beat_d;
            work_q  <= work_d;
        end
    end
endmodule

// File: tb/tb_mixcolumns_engine.sv
// Directed and randomised checks of mixcolumns_engine for COLS_PER_CYCLE 1, 2 and 4.
module tb_mixcolumns_engine;
    localparam logic [127:0] V_IN   = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] V_OUT  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] RT_IN  = 128'hc6c6c6c6_d4d4d4d5_2d26314c_01010101;
    localparam logic [127:0] RT_OUT = 128'hc6c6c6c6_d5d5d7d6_4d7ebdf8_01010101;
    localparam logic [127:0] BYP    = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam int N_RAND = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready, in_ready, out_valid;
    logic [1:0]   mode_i;
    logic [127:0] state_i, state_o;
    logic         iv_x, or_x, ir2, ov2, ir4, ov4;
    logic [127:0] so2, so4;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mixcolumns_engine #(.COLS_PER_CYCLE(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode_i(mode_i), .state_i(state_i), .out_valid(out_valid), .out_ready(out_ready), .state_o(state_o));
    mixcolumns_engine #(.COLS_PER_CYCLE(2)) u2 (.clk(clk), .rst(rst), .in_valid(iv_x), .in_ready(ir2),
        .mode_i(mode_i), .state_i(state_i), .out_valid(ov2), .out_ready(or_x), .state_o(so2));
    mixcolumns_engine #(.COLS_PER_CYCLE(4)) u4 (.clk(clk), .rst(rst), .in_valid(iv_x), .in_ready(ir4),
        .mode_i(mode_i), .state_i(state_i), .out_valid(ov4), .out_ready(or_x), .state_o(so4));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s, input logic [1:0] m);
        logic [127:0] r;
        logic [7:0]   a [4];
        r = s;
        if (!m[1]) begin
            for (int c = 0; c < 4; c++) begin
                for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
                for (int k = 0; k < 4; k++)
                    r[127-32*c-8*k -: 8] = (m == 2'b00)
                        ? (gmul(a[k], 8'h02) ^ gmul(a[(k+1)%4], 8'h03) ^ a[(k+2)%4] ^ a[(k+3)%4])
                        : (gmul(a[k], 8'h0e) ^ gmul(a[(k+1)%4], 8'h0b) ^ gmul(a[(k+2)%4], 8'h0d)
                           ^ gmul(a[(k+3)%4], 8'h09));
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer on u1: accept, wait for out_valid (bounded), capture, then drain with out_ready.
    task automatic xfer(input logic [127:0] s, input logic [1:0] m, output logic [127:0] res, output int lat);
        @(negedge clk);
        state_i = s; mode_i = m; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = state_o;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    logic [127:0] res, held, rt_mid;
    logic [127:0] q_exp [$];
    logic [127:0] exp_v;
    int  lat, l1, l2, l4, sent, got, dcyc, mcyc, n;
    bit  stable, spurious, pend;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; iv_x = 1'b0; or_x = 1'b0;
        mode_i = 2'b00; state_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset in_ready", 128'(in_ready), 128'd1);
        check("reset state_o", state_o, 128'd0);

        // Forward transform and latency on all three widths.
        @(negedge clk);
        state_i = V_IN; mode_i = 2'b00; in_valid = 1'b1; iv_x = 1'b1;
        l1 = 0; l2 = 0; l4 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin in_valid = 1'b0; iv_x = 1'b0; end
            if (out_valid && l1 == 0) l1 = k;
            if (ov2 && l2 == 0) l2 = k;
            if (ov4 && l4 == 0) l4 = k;
        end
        check("latency C1", 128'(l1), 128'd5);
        check("latency C2", 128'(l2), 128'd3);
        check("latency C4", 128'(l4), 128'd2);
        check("mix C1", state_o, V_OUT);
        check("mix C2", so2, V_OUT);
        check("mix C4", so4, V_OUT);
        @(negedge clk); out_ready = 1'b1; or_x = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0; or_x = 1'b0;

        xfer(V_OUT, 2'b01, res, lat);
        check("invmix", res, V_IN);
        check("invmix latency", 128'(lat), 128'd5);

        xfer(RT_IN, 2'b00, rt_mid, lat);
        check("roundtrip fwd", rt_mid, RT_OUT);
        xfer(rt_mid, 2'b01, res, lat);
        check("roundtrip inv", res, RT_IN);

        xfer(BYP, 2'b10, res, lat);
        check("bypass 10", res, BYP);
        check("bypass latency", 128'(lat), 128'd5);
        xfer(V_IN, 2'b11, res, lat);
        check("bypass 11", res, V_IN);

        // Backpressure in DONE, then chain a second state with the handshake.
        @(negedge clk);
        state_i = V_IN; mode_i = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        held = state_o;
        check("stall result", held, V_OUT);
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (state_o !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
        end
        check("stall stable", 128'(stable), 128'd1);
        @(negedge clk);
        state_i = V_OUT; mode_i = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("chain in_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b0;
        check("chain busy", 128'(out_valid), 128'd0);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("chain result", state_o, V_IN);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;

        // Inputs changing while BUSY are ignored.
        @(negedge clk);
        state_i = RT_IN; mode_i = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        state_i = BYP; mode_i = 2'b01;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("busy inputs ignored", state_o, RT_OUT);
        in_valid = 1'b0;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;

        // Reset on beat 1 discards the in-flight state.
        @(negedge clk);
        state_i = V_IN; mode_i = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("midrst out_valid", 128'(out_valid), 128'd0);
        check("midrst in_ready", 128'(in_ready), 128'd1);
        check("midrst state_o", state_o, 128'd0);
        spurious = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (out_valid) spurious = 1'b1; end
        check("midrst no pulse", 128'(spurious), 128'd0);
        xfer(V_IN, 2'b00, res, lat);
        check("after reset mix", res, V_OUT);

        // Random traffic with stalls against the reference model.
        sent = 0; got = 0; dcyc = 0; mcyc = 0; pend = 1'b0;
        fork
            begin
                while (sent < N_RAND && dcyc < 40000) begin
                    @(negedge clk); dcyc++;
                    if (!pend && $urandom_range(3) != 0) begin
                        state_i = {$urandom(), $urandom(), $urandom(), $urandom()};
                        mode_i  = 2'($urandom_range(3));
                        pend    = 1'b1;
                    end
                    in_valid = pend;
                    #1;
                    if (in_valid && in_ready) begin
                        q_exp.push_back(ref_model(state_i, mode_i));
                        sent++;
                        pend = 1'b0;
                    end
                end
                @(negedge clk); in_valid = 1'b0;
            end
            begin
                while (got < N_RAND && mcyc < 40000) begin
                    @(negedge clk); mcyc++;
                    out_ready = ($urandom_range(2) != 0);
                    #1;
                    if (out_valid && out_ready) begin
                        if (q_exp.size() == 0) begin
                            check("random orphan output", state_o, 128'hx);
                        end else begin
                            exp_v = q_exp.pop_front();
                            check("random result", state_o, exp_v);
                        end
                        got++;
                    end
                end
                out_ready = 1'b0;
            end
        join
        check("random count", 128'(got), 128'(N_RAND));
        check("random queue empty", 128'(q_exp.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
